// File: rtl/axi4_b_drop_sender.sv
// Write-response side of the RAB slave port: forwards downstream B beats upstream and
// locally terminates dropped write bursts with an SLVERR response carrying the dropped ID/USER.
module axi4_b_drop_sender #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arstn,
  input  logic                      drop_valid,
  output logic                      drop_ready,
  input  logic [AXI_ID_WIDTH-1:0]   drop_id,
  input  logic [AXI_USER_WIDTH-1:0] drop_user,
  input  logic                      s_axi4_wvalid,
  input  logic                      s_axi4_wlast,
  output logic                      s_axi4_wready,
  output logic                      w_sinking,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi4_bid,
  input  logic [1:0]                m_axi4_bresp,
  input  logic [AXI_USER_WIDTH-1:0] m_axi4_buser,
  input  logic                      m_axi4_bvalid,
  output logic                      m_axi4_bready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi4_bid,
  output logic [1:0]                s_axi4_bresp,
  output logic [AXI_USER_WIDTH-1:0] s_axi4_buser,
  output logic                      s_axi4_bvalid,
  input  logic                      s_axi4_bready
);

  typedef enum logic [1:0] {IDLE, SINK_W, RESP} state_e;

  state_e                    state_q, state_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [AXI_USER_WIDTH-1:0] user_q, user_d;
  logic                      lock_q, lock_d;
  logic                      sel_q, sel_d;
  logic                      last_local_q, last_local_d;
  logic                      drop_ready_q, drop_ready_d;
  logic                      sink_q, sink_d;

  logic local_valid;
  logic grant_local;
  logic b_hs;

  // A presented-but-unaccepted beat keeps its source; otherwise round-robin on a tie.
  always_comb begin
    local_valid = (state_q == RESP);
    if (lock_q) begin
      grant_local = sel_q;
    end else if (local_valid && m_axi4_bvalid) begin
      grant_local = !last_local_q;
    end else begin
      grant_local = local_valid;
    end
  end

  always_comb begin
    s_axi4_bvalid = 1'b0;
    s_axi4_bid    = '0;
    s_axi4_bresp  = 2'b00;
    s_axi4_buser  = '0;
    m_axi4_bready = 1'b0;
    if (grant_local) begin
      if (local_valid) begin
        s_axi4_bvalid = 1'b1;
        s_axi4_bid    = id_q;
        s_axi4_bresp  = 2'b10;
        s_axi4_buser  = user_q;
      end
    end else if (m_axi4_bvalid) begin
      s_axi4_bvalid = 1'b1;
      s_axi4_bid    = m_axi4_bid;
      s_axi4_bresp  = m_axi4_bresp;
      s_axi4_buser  = m_axi4_buser;
      m_axi4_bready = s_axi4_bready;
    end
  end

  assign b_hs = s_axi4_bvalid && s_axi4_bready;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    user_d  = user_q;
    case (state_q)
      IDLE: begin
        if (drop_valid) begin
          state_d = SINK_W;
          id_d    = drop_id;
          user_d  = drop_user;
        end
      end
      SINK_W: begin
        if (s_axi4_wvalid && s_axi4_wlast) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (b_hs && grant_local) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    lock_d       = s_axi4_bvalid && !s_axi4_bready;
    sel_d        = grant_local;
    last_local_d = b_hs ? grant_local : last_local_q;
    // Handshake-side outputs are registered from the next state.
    drop_ready_d = (state_d == IDLE);
    sink_d       = (state_d == SINK_W);
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      state_q      <= IDLE;
      id_q         <= '0;
      user_q       <= '0;
      lock_q       <= 1'b0;
      sel_q        <= 1'b0;
      last_local_q <= 1'b0;
      drop_ready_q <= 1'b1;
      sink_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      user_q       <= user_d;
      lock_q       <= lock_d;
      sel_q        <= sel_d;
      last_local_q <= last_local_d;
      drop_ready_q <= drop_ready_d;
      sink_q       <= sink_d;
    end
  end

  assign drop_ready    = drop_ready_q;
  assign w_sinking     = sink_q;
  assign s_axi4_wready = sink_q;

endmodule

// File: tb/tb_axi4_b_drop_sender.sv
// Bench for axi4_b_drop_sender: passthrough vectors, directed drop/lock/contention/reset
// sequences, and randomized traffic against a transaction-level reference model.
module tb_axi4_b_drop_sender;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       drop_valid, drop_ready;
  logic [3:0] drop_id, drop_user;
  logic       wvalid, wlast, wready, w_sinking;
  logic [3:0] m_bid, m_buser, s_bid, s_buser;
  logic [1:0] m_bresp, s_bresp;
  logic       m_bvalid, m_bready, s_bvalid, s_bready;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  axi4_b_drop_sender #(.AXI_ID_WIDTH(4), .AXI_USER_WIDTH(4)) dut (
    .axi4_aclk(clk), .axi4_arstn(rst_n),
    .drop_valid(drop_valid), .drop_ready(drop_ready), .drop_id(drop_id), .drop_user(drop_user),
    .s_axi4_wvalid(wvalid), .s_axi4_wlast(wlast), .s_axi4_wready(wready), .w_sinking(w_sinking),
    .m_axi4_bid(m_bid), .m_axi4_bresp(m_bresp), .m_axi4_buser(m_buser),
    .m_axi4_bvalid(m_bvalid), .m_axi4_bready(m_bready),
    .s_axi4_bid(s_bid), .s_axi4_bresp(s_bresp), .s_axi4_buser(s_buser),
    .s_axi4_bvalid(s_bvalid), .s_axi4_bready(s_bready)
  );

  // Packed view: {drop_ready, wready, w_sinking, s_bvalid, s_bid, s_bresp, s_buser, m_bready}
  function automatic logic [14:0] ev(input logic dr, input logic wr, input logic sk, input logic bv,
                                     input logic [3:0] id, input logic [1:0] rs,
                                     input logic [3:0] us, input logic mr);
    return {dr, wr, sk, bv, id, rs, us, mr};
  endfunction

  function automatic logic [14:0] obs();
    return {drop_ready, wready, w_sinking, s_bvalid, s_bid, s_bresp, s_buser, m_bready};
  endfunction

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input logic [14:0] exp);
    @(negedge clk);
    chk(name, obs(), exp);
    tick();
  endtask

  task automatic set_m(input logic v, input logic [3:0] id, input logic [1:0] rs, input logic [3:0] us);
    m_bvalid = v; m_bid = id; m_bresp = rs; m_buser = us;
  endtask

  task automatic set_drop(input logic v, input logic [3:0] id, input logic [3:0] us);
    drop_valid = v; drop_id = id; drop_user = us;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_drop(0, 0, 0); wvalid = 0; wlast = 0; set_m(0, 0, 0, 0); s_bready = 0;
    tick();
    chk("reset", obs(), ev(1, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic       mv;
    logic [3:0] mid;
    logic [1:0] mresp;
    logic [3:0] muser;
    logic       sr;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[5];

  // Reference model state (transaction level)
  int         ph;
  logic [3:0] pid, puser;
  bit         turn_local, held, held_local, dh;

  initial begin
    vecs[0] = '{1'b0, 4'h0, 2'd0, 4'h0, 1'b1, ev(1, 0, 0, 0, 4'h0, 2'd0, 4'h0, 0)};
    vecs[1] = '{1'b1, 4'h3, 2'd0, 4'h2, 1'b1, ev(1, 0, 0, 1, 4'h3, 2'd0, 4'h2, 1)};
    vecs[2] = '{1'b1, 4'hA, 2'd3, 4'hF, 1'b0, ev(1, 0, 0, 1, 4'hA, 2'd3, 4'hF, 0)};
    vecs[3] = '{1'b1, 4'hA, 2'd3, 4'hF, 1'b1, ev(1, 0, 0, 1, 4'hA, 2'd3, 4'hF, 1)};
    vecs[4] = '{1'b1, 4'h6, 2'd1, 4'h4, 1'b1, ev(1, 0, 0, 1, 4'h6, 2'd1, 4'h4, 1)};

    do_reset();

    // Passthrough vectors
    for (int i = 0; i < 5; i++) begin
      set_m(vecs[i].mv, vecs[i].mid, vecs[i].mresp, vecs[i].muser);
      s_bready = vecs[i].sr;
      @(negedge clk);
      $display("vec %0d: m_bvalid=%0b bid=%h -> s_bvalid=%0b s_bid=%h m_bready=%0b",
               i, m_bvalid, m_bid, s_bvalid, s_bid, m_bready);
      chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
      tick();
    end

    // Four-beat drop with a W gap, then local B held under backpressure
    do_reset();
    set_drop(1, 4'h5, 4'h9);
    step("d4_idle", ev(1, 0, 0, 0, 0, 0, 0, 0));
    set_drop(0, 0, 0); wvalid = 1;
    step("d4_b1", ev(0, 1, 1, 0, 0, 0, 0, 0));
    step("d4_b2", ev(0, 1, 1, 0, 0, 0, 0, 0));
    wvalid = 0;
    step("d4_gap", ev(0, 1, 1, 0, 0, 0, 0, 0));
    wvalid = 1;
    step("d4_b3", ev(0, 1, 1, 0, 0, 0, 0, 0));
    wlast = 1;
    step("d4_b4", ev(0, 1, 1, 0, 0, 0, 0, 0));
    wvalid = 0; wlast = 0; s_bready = 0;
    step("d4_resp", ev(0, 0, 0, 1, 4'h5, 2'd2, 4'h9, 0));
    set_m(1, 4'h7, 2'd0, 4'h1);
    step("bp_1", ev(0, 0, 0, 1, 4'h5, 2'd2, 4'h9, 0));
    step("bp_2", ev(0, 0, 0, 1, 4'h5, 2'd2, 4'h9, 0));
    s_bready = 1;
    step("bp_acc", ev(0, 0, 0, 1, 4'h5, 2'd2, 4'h9, 0));
    step("bp_fwd", ev(1, 0, 0, 1, 4'h7, 2'd0, 4'h1, 1));
    set_m(0, 0, 0, 0);
    step("bp_idle", ev(1, 0, 0, 0, 0, 0, 0, 0));

    // Contention, single-beat drops, round-robin tie-break and downstream lock
    do_reset();
    set_m(1, 4'hC, 2'd0, 4'h3); s_bready = 1; set_drop(1, 4'h1, 4'h2);
    step("c0", ev(1, 0, 0, 1, 4'hC, 2'd0, 4'h3, 1));
    set_drop(0, 0, 0); wvalid = 1; wlast = 1;
    step("c1_sink", ev(0, 1, 1, 1, 4'hC, 2'd0, 4'h3, 1));
    wvalid = 0; wlast = 0;
    step("c2_local", ev(0, 0, 0, 1, 4'h1, 2'd2, 4'h2, 0));
    set_drop(1, 4'h2, 4'h4);
    step("c3_fwd", ev(1, 0, 0, 1, 4'hC, 2'd0, 4'h3, 1));
    set_drop(0, 0, 0); wvalid = 1; wlast = 1;
    step("c4_sink", ev(0, 1, 1, 1, 4'hC, 2'd0, 4'h3, 1));
    wvalid = 0; wlast = 0;
    step("c5_local", ev(0, 0, 0, 1, 4'h2, 2'd2, 4'h4, 0));
    set_m(0, 0, 0, 0); set_drop(1, 4'h3, 4'h5);
    step("c6_idle", ev(1, 0, 0, 0, 0, 0, 0, 0));
    set_drop(0, 0, 0); wvalid = 1; wlast = 1;
    step("c7_sink", ev(0, 1, 1, 0, 0, 0, 0, 0));
    wvalid = 0; wlast = 0; set_m(1, 4'hD, 2'd1, 4'h6);
    step("c8_rr_fwd", ev(0, 0, 0, 1, 4'hD, 2'd1, 4'h6, 1));
    step("c9_local", ev(0, 0, 0, 1, 4'h3, 2'd2, 4'h5, 0));
    set_drop(1, 4'h4, 4'h7);
    step("c10_fwd", ev(1, 0, 0, 1, 4'hD, 2'd1, 4'h6, 1));
    set_drop(0, 0, 0); set_m(1, 4'hE, 2'd0, 4'h8); s_bready = 0; wvalid = 1; wlast = 1;
    step("c11_sink", ev(0, 1, 1, 1, 4'hE, 2'd0, 4'h8, 0));
    wvalid = 0; wlast = 0;
    step("c12_lock", ev(0, 0, 0, 1, 4'hE, 2'd0, 4'h8, 0));
    s_bready = 1;
    step("c13_fwd", ev(0, 0, 0, 1, 4'hE, 2'd0, 4'h8, 1));
    set_m(0, 0, 0, 0);
    step("c14_local", ev(0, 0, 0, 1, 4'h4, 2'd2, 4'h7, 0));
    step("c15_idle", ev(1, 0, 0, 0, 0, 0, 0, 0));

    // Reset in the middle of sinking a four-beat burst
    do_reset();
    set_drop(1, 4'h6, 4'h1);
    step("rs_idle", ev(1, 0, 0, 0, 0, 0, 0, 0));
    set_drop(0, 0, 0); wvalid = 1;
    step("rs_b1", ev(0, 1, 1, 0, 0, 0, 0, 0));
    step("rs_b2", ev(0, 1, 1, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1 chk("rs_async", obs(), ev(1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    rst_n = 1'b1; wlast = 1; s_bready = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin wvalid = 0; wlast = 0; end
      step($sformatf("rs_noB%0d", i), ev(1, 0, 0, 0, 0, 0, 0, 0));
    end

    // Randomized traffic against the reference model
    do_reset();
    ph = 0; turn_local = 1; held = 0; held_local = 0; dh = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit loc_av, src_local, bv, acc;
      logic [14:0] e;
      if (!dh) begin
        if ($urandom_range(0, 2) == 0) set_m(0, 0, 0, 0);
        else set_m(1, 4'($urandom), 2'($urandom), 4'($urandom));
      end
      set_drop($urandom_range(0, 3) == 0, 4'($urandom), 4'($urandom));
      wvalid = $urandom_range(0, 1) == 1;
      wlast = $urandom_range(0, 2) == 0;
      s_bready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      loc_av = (ph == 2);
      if (held) src_local = held_local;
      else if (loc_av && m_bvalid) src_local = turn_local;
      else src_local = loc_av;
      if (src_local) begin
        bv = 1; e = ev(ph == 0, ph == 1, ph == 1, 1, pid, 2'd2, puser, 0);
      end else if (m_bvalid) begin
        bv = 1; e = ev(ph == 0, ph == 1, ph == 1, 1, m_bid, m_bresp, m_buser, s_bready);
      end else begin
        bv = 0; e = ev(ph == 0, ph == 1, ph == 1, 0, 0, 0, 0, 0);
      end
      chk($sformatf("rand%0d", cyc), obs(), e);
      acc = bv && s_bready;
      if (acc) begin
        held = 0;
        turn_local = !src_local;
        $display("rand %0d: B accepted src=%s id=%h resp=%0d", cyc,
                 src_local ? "local" : "downstream", s_bid, s_bresp);
      end else if (bv) begin
        held = 1; held_local = src_local;
      end
      case (ph)
        0: if (drop_valid) begin ph = 1; pid = drop_id; puser = drop_user; end
        1: if (wvalid && wlast) ph = 2;
        default: if (acc && src_local) ph = 0;
      endcase
      dh = m_bvalid && !(acc && !src_local);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axi4_b_drop_sender.md
Name: axi4_b_drop_sender

Overview:
- Write-response side of the RAB slave port, the counterpart of the AW request buffering path.
- Forwards downstream B responses to the upstream master and locally terminates writes that the AW path drops on a translation miss or protection fault.
- For each dropped write it sinks the W beats of the burst, then returns one B beat with SLVERR carrying the dropped AWID/AWUSER.
- Arbitrates the local error response against forwarded responses without violating AXI valid/ready stability.

Parameters:
AXI_ID_WIDTH, 4, width of BID and of the drop ID.
AXI_USER_WIDTH, 4, width of BUSER and of the drop USER.

Ports:
axi4_aclk  in  1  clock.
axi4_arstn  in  1  asynchronous active-low reset.
drop_valid  in  1  AW path requests termination of one write burst.
drop_ready  out  1  drop request accepted this cycle when drop_valid && drop_ready.
drop_id  in  AXI_ID_WIDTH  AWID of the dropped burst.
drop_user  in  AXI_USER_WIDTH  AWUSER of the dropped burst.
s_axi4_wvalid  in  1  upstream W valid; observed only while sinking.
s_axi4_wlast  in  1  upstream W last.
s_axi4_wready  out  1  W ready driven by this block; top-level muxes it in while w_sinking=1.
w_sinking  out  1  high while this block owns the W channel.
m_axi4_bid  in  AXI_ID_WIDTH  downstream BID.
m_axi4_bresp  in  2  downstream BRESP.
m_axi4_buser  in  AXI_USER_WIDTH  downstream BUSER.
m_axi4_bvalid  in  1  downstream BVALID.
m_axi4_bready  out  1  downstream BREADY.
s_axi4_bid  out  AXI_ID_WIDTH  upstream BID.
s_axi4_bresp  out  2  upstream BRESP.
s_axi4_buser  out  AXI_USER_WIDTH  upstream BUSER.
s_axi4_bvalid  out  1  upstream BVALID.
s_axi4_bready  in  1  upstream BREADY.

Behaviour:
- Drop FSM states: IDLE, SINK_W, RESP. Reset state is IDLE.
- Registers reset to: id_q=0, user_q=0, lock_q=0, sel_q=0, last_local_q=0.
- IDLE: drop_ready=1. On drop_valid: latch drop_id/drop_user into id_q/user_q and go to SINK_W.
- SINK_W: w_sinking=1, s_axi4_wready=1, drop_ready=0. Each wvalid cycle consumes one beat. A beat with wvalid && wlast goes to RESP next cycle. A single-beat burst therefore spends exactly 1 cycle in SINK_W.
- RESP: w_sinking=0, drop_ready=0. A local candidate is pending: bid=id_q, buser=user_q, bresp=2'b10. On the upstream handshake with the local source granted, go to IDLE. The next drop can be accepted in the following cycle.
- Outside SINK_W: s_axi4_wready=0 and w_sinking=0.
- B arbitration, combinational grant with a registered lock:
  - lock_q=1 means a presented beat was not yet accepted; the grant stays sel_q, and the source's id/resp/user/valid must not change.
  - lock_q=0 with one candidate: grant that candidate.
  - lock_q=0 with both candidates: round-robin. Grant local if last_local_q=0, else downstream.
  - lock_q sets when s_axi4_bvalid && !s_axi4_bready, and clears on handshake.
  - last_local_q updates on every handshake: 1 if the local source won, 0 otherwise.
- Datapath: when downstream is granted, s_axi4_b* = m_axi4_b* and m_axi4_bready = s_axi4_bready. Otherwise m_axi4_bready=0.
- With no candidate, s_axi4_bvalid=0; bid/bresp/buser are don't-care and driven 0.
- Latency: downstream forward has 0 cycles combinational. Local B is presented in the cycle after the wlast beat.
- No ID ordering check between local and forwarded responses. Ordering across IDs is legal AXI; same-ID ordering is guaranteed by the AW path stalling same-ID drops behind outstanding writes (outside this block).
- Reset mid-operation: all state returns to IDLE and lock/sel clear immediately. Any pending local response and partially sunk burst are discarded.
- After reset, all outputs are 0 except drop_ready=1, and except the combinational downstream passthrough when m_axi4_bvalid=1.

Test Plan:
- Forward: m_bvalid=1, bid=3, bresp=OKAY, s_bready=1, no drop → same-cycle s_bvalid=1, bid=3, resp=0, m_bready=1.
- Drop with len=4: drop_id=5, user=9; 4 W beats, last one wlast, with a wvalid gap after beat 2 → wready=1 for exactly the SINK_W cycles. Next cycle s_bvalid=1, bid=5, buser=9, bresp=2'b10. drop_ready=0 until the B handshake.
- Backpressure lock: local B presented, s_bready=0 for 3 cycles while m_bvalid rises → s_b* stays local/id 5 and m_bready=0 throughout. After accept, the downstream beat is forwarded next.
- Contention: continuous m_bvalid plus 2 back-to-back drops → upstream sees local, downstream, local alternating; no starvation.
- Single-beat drop: drop, then wvalid&&wlast in the first SINK_W cycle → 1-cycle SINK_W, B in the following cycle.
- Reset mid-SINK_W after 2 of 4 beats → wready=0, w_sinking=0, drop_ready=1, and no B is ever issued for the dropped ID.
